uc_multiciclo: RTL and testbench

- Multi-cycle control unit for the MIPS datapath.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Drives the same control-signal set as the single-cycle decoder, plus IR/PC write enables and a memory request handshake.
- Sits beside the datapath; one shared memory port serves both instruction fetch and lw/sw.
- Counts retired instructions.

---
 rtl/uc_multiciclo.sv | 219 +++++++++++++++++++++
 tb/tb_uc_multiciclo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port,
// driving the datapath control set plus IR/PC write enables, and counting retired instructions.
module uc_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       inscod,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             RegDist,
  output logic             Branch,
  output logic             MemRead,
  output logic             Memtoreg,
  output logic [3:0]       ALUop,
  output logic             MemWrite,
  output logic             ALUsrc,
  output logic             Regwrite,
  output logic             jump,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     st;
  state_t     st_nxt;
  logic [5:0] op_q;
  logic       retire;

  function automatic logic [3:0] alu_of(input logic [5:0] op);
    case (op)
      OP_R:    alu_of = 4'b0111;
      OP_ADDI: alu_of = 4'b0001;
      OP_ANDI: alu_of = 4'b0000;
      OP_ORI:  alu_of = 4'b0010;
      OP_SLTI: alu_of = 4'b0011;
      OP_BEQ:  alu_of = 4'b0101;
      OP_LW:   alu_of = 4'b1000;
      OP_SW:   alu_of = 4'b0100;
      OP_J:    alu_of = 4'b0110;
      default: alu_of = 4'b0000;
    endcase
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    is_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  function automatic logic supported(input logic [5:0] op);
    supported = (op == OP_R) || is_imm(op) || (op == OP_LW) || (op == OP_SW) ||
                (op == OP_BEQ) || (op == OP_J);
  endfunction

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= FETCH;
      op_q    <= 6'd0;
      instret <= '0;
    end else begin
      st <= st_nxt;
      if (st == DECODE)
        op_q <= inscod;
      if (retire)
        instret <= instret + CNT_ONE;
    end
  end

  // Outputs depend on state and op_q; DECODE looks at inscod because op_q is only loaded at its end.
  always_comb begin
    st_nxt   = st;
    retire   = 1'b0;
    mem_req  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PC_SEQ;
    RegDist  = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    Memtoreg = 1'b0;
    ALUop    = 4'b0000;
    MemWrite = 1'b0;
    ALUsrc   = 1'b0;
    Regwrite = 1'b0;
    jump     = 1'b0;
    illegal  = 1'b0;

    case (st)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          st_nxt  = DECODE;
        end
      end

      DECODE: begin
        if (supported(inscod)) begin
          st_nxt = EXEC;
        end else begin
          illegal = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = PC_SEQ;
          st_nxt  = FETCH;
        end
      end

      EXEC: begin
        ALUop   = alu_of(op_q);
        RegDist = (op_q == OP_R);
        if (op_q == OP_R) begin
          st_nxt = WB;
        end else if (is_imm(op_q)) begin
          ALUsrc = 1'b1;
          st_nxt = WB;
        end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          ALUsrc = 1'b1;
          st_nxt = MEM;
        end else if (op_q == OP_BEQ) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = zero ? PC_BR : PC_SEQ;
          retire  = 1'b1;
          st_nxt  = FETCH;
        end else if (op_q == OP_J) begin
          jump    = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = PC_JMP;
          retire  = 1'b1;
          st_nxt  = FETCH;
        end else begin
          st_nxt = FETCH;
        end
      end

      MEM: begin
        mem_req  = 1'b1;
        ALUop    = alu_of(op_q);
        ALUsrc   = 1'b1;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_LW) begin
            st_nxt = WB;
          end else begin
            PCWrite = 1'b1;
            PCSrc   = PC_SEQ;
            retire  = 1'b1;
            st_nxt  = FETCH;
          end
        end
      end

      WB: begin
        ALUop    = alu_of(op_q);
        ALUsrc   = (op_q != OP_R);
        Regwrite = 1'b1;
        PCWrite  = 1'b1;
        PCSrc    = PC_SEQ;
        RegDist  = (op_q == OP_R);
        Memtoreg = (op_q == OP_LW);
        retire   = 1'b1;
        st_nxt   = FETCH;
      end

      default: st_nxt = FETCH;
    endcase

    // Reset silences every strobe at once so an abandoned instruction cannot write anything.
    if (rst) begin
      st_nxt   = FETCH;
      retire   = 1'b0;
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = PC_SEQ;
      RegDist  = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      Memtoreg = 1'b0;
      ALUop    = 4'b0000;
      MemWrite = 1'b0;
      ALUsrc   = 1'b0;
      Regwrite = 1'b0;
      jump     = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: vector table of instructions plus reset, wait-state and
// counter-wrap sequences; a CNT_W=4 copy shares all inputs to exercise the wrap.
module tb_uc_multiciclo;

  logic        clk;
  logic        rst;
  logic [5:0]  inscod;
  logic        zero;
  logic        mem_ready;

  logic        mem_req, IRWrite, PCWrite, RegDist, Branch, MemRead, Memtoreg;
  logic        MemWrite, ALUsrc, Regwrite, jump, illegal;
  logic [1:0]  PCSrc;
  logic [3:0]  ALUop;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        d4_mem_req, d4_IRWrite, d4_PCWrite, d4_RegDist, d4_Branch, d4_MemRead, d4_Memtoreg;
  logic        d4_MemWrite, d4_ALUsrc, d4_Regwrite, d4_jump, d4_illegal;
  logic [1:0]  d4_PCSrc;
  logic [3:0]  d4_ALUop;
  logic [2:0]  d4_state;
  logic [3:0]  d4_instret;

  uc_multiciclo #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .inscod(inscod), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegDist(RegDist), .Branch(Branch), .MemRead(MemRead), .Memtoreg(Memtoreg),
    .ALUop(ALUop), .MemWrite(MemWrite), .ALUsrc(ALUsrc), .Regwrite(Regwrite),
    .jump(jump), .illegal(illegal), .state(state), .instret(instret)
  );

  uc_multiciclo #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .inscod(inscod), .zero(zero), .mem_ready(mem_ready),
    .mem_req(d4_mem_req), .IRWrite(d4_IRWrite), .PCWrite(d4_PCWrite), .PCSrc(d4_PCSrc),
    .RegDist(d4_RegDist), .Branch(d4_Branch), .MemRead(d4_MemRead), .Memtoreg(d4_Memtoreg),
    .ALUop(d4_ALUop), .MemWrite(d4_MemWrite), .ALUsrc(d4_ALUsrc), .Regwrite(d4_Regwrite),
    .jump(d4_jump), .illegal(d4_illegal), .state(d4_state), .instret(d4_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         cyc;
    logic [2:0] fst;
    logic [1:0] pcsrc;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       jmp;
    logic       br;
    logic       ill;
    logic [3:0] alu;
    int         ret;
  } vec_t;

  vec_t vt[12];

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ret = 0;

  int          cyc_n, memrd_n, br_n, bad_n;
  logic        done;
  logic [29:0] seq;
  logic [2:0]  f_state;
  logic [1:0]  f_pcsrc;
  logic        f_rw, f_rd, f_m2r, f_jmp, f_br, f_ill;
  logic [3:0]  f_alu;

  function automatic logic [17:0] ctrl_vec();
    ctrl_vec = {mem_req, IRWrite, PCWrite, PCSrc, RegDist, Branch, MemRead, Memtoreg,
                ALUop, MemWrite, ALUsrc, Regwrite, jump, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Runs one instruction from FETCH up to and including its PCWrite cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    int fcnt;
    int mcnt;
    fcnt = 0; mcnt = 0;
    cyc_n = 0; memrd_n = 0; br_n = 0; bad_n = 0; done = 1'b0; seq = '0;
    inscod = op;
    zero   = z;
    while (!done && cyc_n < 40) begin
      if (state == 3'd0) begin
        mem_ready = (fcnt >= fw);
        fcnt++;
      end else if (state == 3'd3) begin
        mem_ready = (mcnt >= mw);
        mcnt++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      seq = {seq[26:0], state};
      cyc_n++;
      if (MemRead && mem_req) memrd_n++;
      if (Branch) br_n++;
      if (Regwrite && state != 3'd4) bad_n++;
      if (MemWrite && state != 3'd3) bad_n++;
      if (PCWrite) begin
        done    = 1'b1;
        f_state = state;
        f_pcsrc = PCSrc;
        f_rw    = Regwrite;
        f_rd    = RegDist;
        f_m2r   = Memtoreg;
        f_jmp   = jump;
        f_br    = Branch;
        f_ill   = illegal;
        f_alu   = ALUop;
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL timeout: instruction %b got no PCWrite within 40 cycles, required one", op);
    end
  endtask

  initial begin
    vt[0]  = '{6'b000000, 1'b0, 0, 0, 4, 3'd4, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1};
    vt[1]  = '{6'b001000, 1'b0, 0, 0, 4, 3'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1};
    vt[2]  = '{6'b001100, 1'b0, 0, 0, 4, 3'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1};
    vt[3]  = '{6'b001101, 1'b0, 2, 0, 6, 3'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1};
    vt[4]  = '{6'b001010, 1'b0, 0, 0, 4, 3'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1};
    vt[5]  = '{6'b100011, 1'b0, 0, 3, 8, 3'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1};
    vt[6]  = '{6'b101011, 1'b0, 0, 0, 4, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1};
    vt[7]  = '{6'b000100, 1'b1, 0, 0, 3, 3'd2, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 1};
    vt[8]  = '{6'b000100, 1'b0, 0, 0, 3, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 1};
    vt[9]  = '{6'b000010, 1'b0, 0, 0, 3, 3'd2, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1};
    vt[10] = '{6'b111111, 1'b0, 0, 0, 2, 3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 0};
    vt[11] = '{6'b101011, 1'b0, 0, 2, 6, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1};

    rst = 1'b1; inscod = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_ctrl", {14'd0, ctrl_vec()}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_state", {29'd0, state}, 32'd0);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_irwrite", {31'd0, IRWrite}, 32'd0);
    @(posedge clk); #1;
    chk("fetch_hold_state", {29'd0, state}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_instr(vt[i].op, vt[i].z, vt[i].fw, vt[i].mw);
      exp_ret += vt[i].ret;
      chk($sformatf("v%0d_cycles", i), cyc_n, vt[i].cyc);
      chk($sformatf("v%0d_final_state", i), {29'd0, f_state}, {29'd0, vt[i].fst});
      chk($sformatf("v%0d_pcsrc", i), {30'd0, f_pcsrc}, {30'd0, vt[i].pcsrc});
      chk($sformatf("v%0d_regwrite", i), {31'd0, f_rw}, {31'd0, vt[i].rw});
      chk($sformatf("v%0d_regdist", i), {31'd0, f_rd}, {31'd0, vt[i].rd});
      chk($sformatf("v%0d_memtoreg", i), {31'd0, f_m2r}, {31'd0, vt[i].m2r});
      chk($sformatf("v%0d_jump", i), {31'd0, f_jmp}, {31'd0, vt[i].jmp});
      chk($sformatf("v%0d_branch", i), {31'd0, f_br}, {31'd0, vt[i].br});
      chk($sformatf("v%0d_illegal", i), {31'd0, f_ill}, {31'd0, vt[i].ill});
      chk($sformatf("v%0d_aluop", i), {28'd0, f_alu}, {28'd0, vt[i].alu});
      chk($sformatf("v%0d_stray_write", i), bad_n, 0);
      chk($sformatf("v%0d_back_to_fetch", i), {29'd0, state}, 32'd0);
      chk($sformatf("v%0d_instret", i), instret, exp_ret);
      chk($sformatf("v%0d_instret4", i), {28'd0, d4_instret}, exp_ret % 16);
    end

    run_instr(6'b000000, 1'b0, 0, 0);
    exp_ret++;
    chk("add_state_seq", {2'd0, seq}, {20'd0, 3'd0, 3'd1, 3'd2, 3'd4});
    chk("add_instret", instret, exp_ret);

    run_instr(6'b100011, 1'b0, 0, 3);
    exp_ret++;
    chk("lw_state_seq", {2'd0, seq}, {8'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4});
    chk("lw_memread_cycles", memrd_n, 4);
    chk("lw_branch_cycles", br_n, 0);

    while ((exp_ret % 16) != 15) begin
      run_instr(6'b001000, 1'b0, 0, 0);
      exp_ret++;
    end
    chk("wrap_pre_all_ones", {28'd0, d4_instret}, 32'd15);
    run_instr(6'b001000, 1'b0, 0, 0);
    exp_ret++;
    chk("wrap_to_zero", {28'd0, d4_instret}, 32'd0);
    chk("wide_no_wrap", instret, exp_ret);

    // sw stalled in MEM, then reset lands mid-cycle
    inscod = 6'b101011;
    for (int k = 0; k < 10; k++) begin
      mem_ready = (state != 3'd3);
      #1;
      if (state == 3'd3) break;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1;
    chk("sw_stall_state", {29'd0, state}, 32'd3);
    chk("sw_stall_memwrite", {31'd0, MemWrite}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {14'd0, ctrl_vec()}, 32'd0);
    chk("midrst_state", {29'd0, state}, 32'd0);
    chk("midrst_instret", instret, 32'd0);
    @(posedge clk); #1;
    chk("midrst_hold_memwrite", {31'd0, MemWrite}, 32'd0);
    rst = 1'b0;
    exp_ret = 0;
    #1;
    chk("midrst_release_state", {29'd0, state}, 32'd0);
    chk("midrst_release_mem_req", {31'd0, mem_req}, 32'd1);
    chk("midrst_instret4", {28'd0, d4_instret}, 32'd0);
    run_instr(6'b000000, 1'b0, 0, 0);
    exp_ret++;
    chk("after_rst_add_instret", instret, exp_ret);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
